// File: rtl/jt1943_sndcmd.sv
// Main-CPU-side sound command driver: queues command bytes, writes them to the
// sound latch with a guaranteed hold time, and generates snd_int and sres_b.
module jt1943_sndcmd #(
   parameter int FIFO_AW = 3,
   parameter int HOLD    = 64,
   parameter int INT_DIV = 12500,
   parameter int INT_W   = 8,
   parameter int RST_LEN = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cen3,
   input  logic               main_cen,
   input  logic               cmd_we,
   input  logic [7:0]         cmd_data,
   input  logic               sres_req,
   output logic               cmd_full,
   output logic [FIFO_AW:0]   cmd_level,
   output logic               cmd_ovf,
   output logic               busy,
   output logic [7:0]         main_dout,
   output logic               main_latch_cs,
   output logic               snd_int,
   output logic               sres_b
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam int HW    = $clog2(HOLD);
   localparam int IW    = $clog2(INT_DIV);
   localparam int RW    = $clog2(RST_LEN + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_HOLD} st_t;

   // ---------------- sound reset ----------------
   logic [RW-1:0] rst_cnt_q;
   logic          sres_b_q;
   logic          flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_cnt_q <= RW'(RST_LEN);
         sres_b_q  <= 1'b0;
      end else if (sres_req) begin
         rst_cnt_q <= RW'(RST_LEN);
         sres_b_q  <= 1'b0;
      end else if (!sres_b_q && cen3) begin
         if (rst_cnt_q <= RW'(1)) begin
            rst_cnt_q <= '0;
            sres_b_q  <= 1'b1;
         end else begin
            rst_cnt_q <= rst_cnt_q - 1'b1;
         end
      end
   end

   // A pending request counts as reset already, so a same-clk push loses.
   assign flush = sres_req | ~sres_b_q;

   // ---------------- interrupt timer ----------------
   logic [IW-1:0] cnt_q;
   logic          int_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         int_q <= 1'b0;
      end else if (flush) begin
         cnt_q <= '0;
         int_q <= 1'b0;
      end else if (cen3) begin
         int_q <= (cnt_q < IW'(INT_W));
         cnt_q <= (cnt_q == IW'(INT_DIV - 1)) ? '0 : cnt_q + 1'b1;
      end
   end

   // ---------------- command FIFO ----------------
   logic [7:0]         mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_q, rd_q;
   logic [FIFO_AW:0]   level_q;
   logic               ovf_q;
   logic               push, pop;

   assign cmd_full = (level_q == (FIFO_AW+1)'(DEPTH));
   assign push     = cmd_we & ~cmd_full & ~flush;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= cmd_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         level_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         ovf_q <= cmd_we & ~push;
         if (flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
         end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            unique case ({push, pop})
               2'b10:   level_q <= level_q + 1'b1;
               2'b01:   level_q <= level_q - 1'b1;
               default: level_q <= level_q;
            endcase
         end
      end
   end

   // ---------------- latch writer ----------------
   st_t           state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [7:0]    dout_q, dout_d;
   logic          cs_q, cs_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         hold_q  <= '0;
         dout_q  <= 8'h00;
         cs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         dout_q  <= dout_d;
         cs_q    <= cs_d;
      end
   end

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      dout_d  = dout_q;
      cs_d    = cs_q;
      pop     = 1'b0;
      if (flush) begin
         state_d = ST_IDLE;
         cs_d    = 1'b0;
      end else if (main_cen) begin
         unique case (state_q)
            ST_IDLE: if (level_q != '0) begin
               dout_d  = mem_q[rd_q];
               cs_d    = 1'b1;
               pop     = 1'b1;
               state_d = ST_WRITE;
            end
            ST_WRITE: begin
               cs_d    = 1'b0;
               hold_d  = HW'(HOLD - 1);
               state_d = ST_HOLD;
            end
            ST_HOLD: begin
               if (hold_q == '0) state_d = ST_IDLE;
               else              hold_d  = hold_q - 1'b1;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign cmd_level     = level_q;
   assign cmd_ovf       = ovf_q;
   assign busy          = (level_q != '0) | (state_q != ST_IDLE);
   assign main_dout     = dout_q;
   assign main_latch_cs = cs_q;
   assign snd_int       = int_q;
   assign sres_b        = sres_b_q;

endmodule

// File: tb/tb_jt1943_sndcmd.sv
// Directed bench for jt1943_sndcmd; a latch-receiver monitor records captured bytes,
// strobe rise times (in main_cen ticks) and strobe width (in clk).
module tb_jt1943_sndcmd;

   localparam int INT_DIV = 100;

   logic       clk = 1'b0;
   logic       rst_n, cmd_we, sres_req, mc_man;
   logic [7:0] cmd_data;
   logic       cen3, main_cen, mc_gen;
   logic       cmd_full, cmd_ovf, busy, main_latch_cs, snd_int, sres_b;
   logic [3:0] cmd_level;
   logic [7:0] main_dout;

   int div3 = 0, mc_div = 0, mc_mode = 0;
   int cen3_cnt = 0, mc_cnt = 0;
   logic [7:0] rx_mem [256];
   int rise_mc [64];
   int rx_n = 0, rise_n = 0, w_cnt = 0, width_last = 0;
   logic cs_prev = 1'b0;
   int n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   assign cen3     = (div3 == 7);
   assign mc_gen   = (mc_mode == 1) || (mc_mode == 4 && mc_div == 3);
   assign main_cen = mc_gen | mc_man;

   jt1943_sndcmd #(.INT_DIV(INT_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .cen3(cen3), .main_cen(main_cen),
      .cmd_we(cmd_we), .cmd_data(cmd_data), .sres_req(sres_req),
      .cmd_full(cmd_full), .cmd_level(cmd_level), .cmd_ovf(cmd_ovf), .busy(busy),
      .main_dout(main_dout), .main_latch_cs(main_latch_cs),
      .snd_int(snd_int), .sres_b(sres_b)
   );

   // Enable generators plus the receiver model.
   always @(posedge clk) begin
      div3   <= (div3 + 1) % 8;
      mc_div <= (mc_div + 1) % 4;
      if (cen3) cen3_cnt <= cen3_cnt + 1;
      if (main_cen) mc_cnt <= mc_cnt + 1;
      if (main_cen && main_latch_cs) begin
         rx_mem[rx_n] <= main_dout;
         rx_n <= rx_n + 1;
      end
      if (main_latch_cs && !cs_prev) begin
         rise_mc[rise_n] <= mc_cnt;
         rise_n <= rise_n + 1;
      end
      if (main_latch_cs) w_cnt <= w_cnt + 1;
      else if (cs_prev) begin
         width_last <= w_cnt;
         w_cnt <= 0;
      end
      cs_prev <= main_latch_cs;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      @(posedge clk); #1 cmd_we = 1'b1; cmd_data = b;
      @(posedge clk); #1 cmd_we = 1'b0;
   endtask

   task automatic pulse_sres();
      @(posedge clk); #1 sres_req = 1'b1;
      @(posedge clk); #1 sres_req = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 4000 && busy; i++) @(negedge clk);
      check(tag, busy, 1'b0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, rb, rs;
      rst_n = 1'b0; cmd_we = 1'b0; cmd_data = 8'h00; sres_req = 1'b0; mc_man = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_sres_b", sres_b, 0);
      check("rst_snd_int", snd_int, 0);
      check("rst_cs", main_latch_cs, 0);
      check("rst_dout", main_dout, 0);
      check("rst_level", cmd_level, 0);
      check("rst_busy", busy, 0);
      check("rst_ovf", cmd_ovf, 0);

      // 1: power-up reset length and interrupt timing
      rst_n = 1'b1;
      t0 = cen3_cnt;
      for (int i = 0; i < 400 && !sres_b; i++) @(negedge clk);
      check("pwr_sres_b_high", sres_b, 1);
      check("pwr_rst_len", cen3_cnt - t0, 16);
      t1 = cen3_cnt;
      for (int i = 0; i < 100 && !snd_int; i++) @(negedge clk);
      check("int_first_rise", snd_int, 1);
      check("int_rise_delay", cen3_cnt - t1, 1);
      t1 = cen3_cnt;
      for (int i = 0; i < 200 && snd_int; i++) @(negedge clk);
      check("int_fall", snd_int, 0);
      check("int_width", cen3_cnt - t1, 8);
      for (int i = 0; i < 2000 && !snd_int; i++) @(negedge clk);
      check("int_second_rise", snd_int, 1);
      check("int_period", cen3_cnt - t1, INT_DIV);

      // 2: three bytes, main_cen 1-in-4
      mc_mode = 4; rb = rx_n; rs = rise_n;
      push(8'h10); push(8'h20); push(8'h30);
      wait_idle("seq3_idle");
      check("seq3_count", rx_n - rb, 3);
      check("seq3_b0", rx_mem[rb], 8'h10);
      check("seq3_b1", rx_mem[rb+1], 8'h20);
      check("seq3_b2", rx_mem[rb+2], 8'h30);
      check("seq3_gap01", rise_mc[rs+1] - rise_mc[rs], 66);
      check("seq3_gap12", rise_mc[rs+2] - rise_mc[rs+1], 66);
      check("strobe_w_div4", width_last, 4);

      // 6: main_cen tied high
      mc_mode = 1; rb = rx_n;
      push(8'h5A);
      wait_idle("tied_idle");
      check("tied_count", rx_n - rb, 1);
      check("tied_b0", rx_mem[rb], 8'h5A);
      check("strobe_w_tied", width_last, 1);

      // 3: overflow with writer stalled, then drain
      mc_mode = 0;
      for (int k = 0; k < 8; k++) push(8'(8'h81 + k));
      @(negedge clk);
      check("fill_full", cmd_full, 1);
      check("fill_level", cmd_level, 8);
      check("fill_no_ovf", cmd_ovf, 0);
      push(8'h89);
      @(negedge clk);
      check("ovf_pulse", cmd_ovf, 1);
      check("ovf_level", cmd_level, 8);
      @(negedge clk);
      check("ovf_one_clk", cmd_ovf, 0);
      rb = rx_n; mc_mode = 1;
      wait_idle("drain_idle");
      check("drain_count", rx_n - rb, 8);
      for (int k = 0; k < 8; k++) check("drain_byte", rx_mem[rb+k], 8'(8'h81 + k));

      // 4: push while full in the same clk as a pop
      mc_mode = 0;
      for (int k = 0; k < 8; k++) push(8'(8'h81 + k));
      @(posedge clk); #1 cmd_we = 1'b1; cmd_data = 8'h99; mc_man = 1'b1;
      @(posedge clk); #1 cmd_we = 1'b0; mc_man = 1'b0;
      @(negedge clk);
      check("pp_ovf", cmd_ovf, 1);
      check("pp_level", cmd_level, 7);
      check("pp_dout", main_dout, 8'h81);
      check("pp_cs", main_latch_cs, 1);
      rb = rx_n; mc_mode = 1;
      wait_idle("pp_idle");
      check("pp_count", rx_n - rb, 8);
      check("pp_first", rx_mem[rb], 8'h81);
      check("pp_last", rx_mem[rb+7], 8'h88);

      // 5: sound reset mid-HOLD, then extended by a second request
      mc_mode = 4; rb = rx_n;
      for (int k = 0; k < 5; k++) push(8'(8'hA1 + k));
      for (int i = 0; i < 400 && rx_n == rb; i++) @(negedge clk);
      for (int i = 0; i < 40 && main_latch_cs; i++) @(negedge clk);
      repeat (8) @(negedge clk);
      check("sr_pre_level", cmd_level, 4);
      check("sr_pre_busy", busy, 1);
      pulse_sres();
      @(negedge clk);
      t0 = cen3_cnt;
      check("sr_sres_b", sres_b, 0);
      check("sr_level", cmd_level, 0);
      check("sr_cs", main_latch_cs, 0);
      check("sr_snd_int", snd_int, 0);
      check("sr_busy", busy, 0);
      check("sr_dout_kept", main_dout, 8'hA1);
      push(8'h77);
      @(negedge clk);
      check("sr_push_ovf", cmd_ovf, 1);
      check("sr_push_level", cmd_level, 0);
      for (int i = 0; i < 400 && (cen3_cnt - t0) < 10; i++) @(negedge clk);
      check("sr_low_at10", sres_b, 0);
      pulse_sres();
      for (int i = 0; i < 600 && !sres_b; i++) @(negedge clk);
      check("sr_release", sres_b, 1);
      check("sr_total_len", cen3_cnt - t0, 26);
      t1 = cen3_cnt;
      for (int i = 0; i < 100 && !snd_int; i++) @(negedge clk);
      check("sr_int_rise", cen3_cnt - t1, 1);
      check("sr_no_more_bytes", rx_n - rb, 1);
      check("sr_idle", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
